// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package reg_file_mp_pkg;

  typedef logic [31:0] uint32;

  localparam int unsigned REG_ZERO = 0;

  // Address width for a given register count (at least one bit).
  function automatic int unsigned reg_aw(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int unsigned REG_AW = reg_aw(32);

  typedef logic [REG_AW-1:0] regId_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector: set at issue, cleared at writeback, set wins on a tie.
module reg_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   set_en,
  input  logic [reg_aw(NREGS)-1:0]               set_addr,
  input  logic [NWRITE-1:0]                      wr_en,
  input  logic [NWRITE-1:0][reg_aw(NREGS)-1:0]   wr_addr,
  input  logic [NREAD-1:0][reg_aw(NREGS)-1:0]    rd_addr,
  output logic [NREAD-1:0]                       rd_busy
);

  localparam int unsigned AW = reg_aw(NREGS);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    for (int unsigned w = 0; w < NWRITE; w++) begin
      if (wr_en[w] && (wr_addr[w] != AW'(REG_ZERO))) busy_next[wr_addr[w]] = 1'b0;
    end
    if (set_en && (set_addr != AW'(REG_ZERO))) busy_next[set_addr] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic written;
    logic busy_rd;
    always_comb begin
      written = 1'b0;
      for (int unsigned w = 0; w < NWRITE; w++) begin
        if (wr_en[w] && (wr_addr[w] == rd_addr[r])) written = 1'b1;
      end
      // A pending writeback clears the hazard early unless a new producer is issued.
      if (rd_addr[r] == AW'(REG_ZERO))
        busy_rd = 1'b0;
      else if ((BYPASS != 0) && written && !(set_en && (set_addr == rd_addr[r])))
        busy_rd = 1'b0;
      else
        busy_rd = busy[rd_addr[r]];
    end
    assign rd_busy[r] = busy_rd;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with x0 hardwired to zero, optional bypass and busy scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREAD-1:0][reg_aw(NREGS)-1:0]   rd_addr,
  output logic [NREAD-1:0][XLEN-1:0]            rd_data,
  output logic [NREAD-1:0]                      rd_busy,
  input  logic [NWRITE-1:0]                     wr_en,
  input  logic [NWRITE-1:0][reg_aw(NREGS)-1:0]  wr_addr,
  input  logic [NWRITE-1:0][XLEN-1:0]           wr_data,
  input  logic                                  busy_set_en,
  input  logic [reg_aw(NREGS)-1:0]              busy_set_addr
);

  localparam int unsigned AW = reg_aw(NREGS);

  logic [XLEN-1:0] regs [NREGS-1:1];

  // Ascending port order makes the highest-numbered port win a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWRITE; w++) begin
        if (wr_en[w] && (wr_addr[w] != AW'(REG_ZERO))) regs[wr_addr[w]] <= wr_data[w];
      end
    end
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic [XLEN-1:0] data_rd;
    always_comb begin
      if (rd_addr[r] == AW'(REG_ZERO)) data_rd = '0;
      else                             data_rd = regs[rd_addr[r]];
      if ((BYPASS != 0) && (rd_addr[r] != AW'(REG_ZERO))) begin
        for (int unsigned w = 0; w < NWRITE; w++) begin
          if (wr_en[w] && (wr_addr[w] == rd_addr[r])) data_rd = wr_data[w];
        end
      end
    end
    assign rd_data[r] = data_rd;
  end

  reg_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (busy_set_en),
    .set_addr (busy_set_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: bypass and non-bypass instances against a behavioural model.
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [1:0][4:0]  rd_addr = '0;
  logic [1:0]       wr_en = '0;
  logic [1:0][4:0]  wr_addr = '0;
  logic [1:0][31:0] wr_data = '0;
  logic             busy_set_en = 1'b0;
  logic [4:0]       busy_set_addr = '0;

  logic [1:0][31:0] rd_data_b, rd_data_n;
  logic [1:0]       rd_busy_b, rd_busy_n;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr));

  reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input uint32 act, input uint32 exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural model: register values and pending-producer flags.
  uint32 mreg [32];
  bit    mbusy [32];
  bit    armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mreg[i] = 0; mbusy[i] = 0; end
      armed = 1'b1;
    end else begin
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_addr[w] != 0) begin mreg[wr_addr[w]] = wr_data[w]; mbusy[wr_addr[w]] = 0; end
      if (busy_set_en && busy_set_addr != 0) mbusy[busy_set_addr] = 1;
    end
  end

  function automatic uint32 exp_data(input bit byp, input logic [4:0] a);
    uint32 d;
    if (a == 0) return 0;
    d = mreg[a];
    if (byp) for (int w = 0; w < 2; w++) if (wr_en[w] && wr_addr[w] == a) d = wr_data[w];
    return d;
  endfunction

  function automatic uint32 exp_busy(input bit byp, input logic [4:0] a);
    bit wr_hit;
    if (a == 0) return 0;
    wr_hit = (wr_en[0] && wr_addr[0] == a) || (wr_en[1] && wr_addr[1] == a);
    if (byp && wr_hit && !(busy_set_en && busy_set_addr == a)) return 0;
    return uint32'(mbusy[a]);
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      for (int p = 0; p < 2; p++) begin
        check("model_data_byp", rd_data_b[p], exp_data(1'b1, rd_addr[p]));
        check("model_data_nobyp", rd_data_n[p], exp_data(1'b0, rd_addr[p]));
        check("model_busy_byp", uint32'(rd_busy_b[p]), exp_busy(1'b1, rd_addr[p]));
        check("model_busy_nobyp", uint32'(rd_busy_n[p]), exp_busy(1'b0, rd_addr[p]));
      end
    end
  end

  task automatic apply(input logic r,
                       input logic we0, input logic [4:0] wa0, input uint32 wd0,
                       input logic we1, input logic [4:0] wa1, input uint32 wd1,
                       input logic bse, input logic [4:0] bsa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk); #1;
    rst = r;
    wr_en[0] = we0; wr_addr[0] = wa0; wr_data[0] = wd0;
    wr_en[1] = we1; wr_addr[1] = wa1; wr_data[1] = wd1;
    busy_set_en = bse; busy_set_addr = bsa;
    rd_addr[0] = ra0; rd_addr[1] = ra1;
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
  endtask

  initial begin
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fill every register with a tagged pattern, then reset.
    for (int i = 1; i < 32; i++)
      apply(0, 1, 5'(i), 32'hA5A5_0000 + i, 0, 0, 0, 0, 0, 5'(i), 5'(i - 1));
    idle(1, 31);
    check("fill_x1", rd_data_n[0], 32'hA5A5_0001);
    check("fill_x31", rd_data_n[1], 32'hA5A5_001F);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      check("reset_data", rd_data_n[0], 0);
      check("reset_busy", uint32'(rd_busy_n[1]), 0);
    end

    // x0 ignores writes and busy sets on both paths.
    apply(0, 1, 0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
    check("x0_byp_data0", rd_data_b[0], 0);
    check("x0_byp_data1", rd_data_b[1], 0);
    check("x0_byp_busy", uint32'(rd_busy_b[0]), 0);
    idle(0, 0);
    check("x0_after_data", rd_data_n[1], 0);
    check("x0_after_busy", uint32'(rd_busy_n[1]), 0);

    // Same-cycle bypass versus stored value.
    apply(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 5, 0);
    check("byp_x5_same", rd_data_b[0], 32'h1234);
    check("nobyp_x5_same", rd_data_n[0], 0);
    idle(5, 5);
    check("nobyp_x5_next", rd_data_n[0], 32'h1234);

    // Collision: port 1 wins.
    apply(0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);
    check("coll_byp_same", rd_data_b[1], 32'h22);
    idle(7, 0);
    check("coll_nobyp_next", rd_data_n[0], 32'h22);
    check("coll_byp_next", rd_data_b[0], 32'h22);

    // Scoreboard set, clear, and set-beats-clear.
    apply(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    check("sb_set_same", uint32'(rd_busy_b[0]), 0);
    idle(9, 9);
    check("sb_set_next_b", uint32'(rd_busy_b[0]), 1);
    check("sb_set_next_n", uint32'(rd_busy_n[1]), 1);
    apply(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    check("sb_clr_byp_same", uint32'(rd_busy_b[0]), 0);
    check("sb_clr_nobyp_same", uint32'(rd_busy_n[0]), 1);
    idle(9, 0);
    check("sb_clr_next", uint32'(rd_busy_n[0]), 0);
    apply(0, 1, 9, 32'h9A, 0, 0, 0, 1, 9, 9, 0);
    check("sb_tie_same", uint32'(rd_busy_b[0]), 0);
    idle(9, 9);
    check("sb_tie_next_b", uint32'(rd_busy_b[0]), 1);
    check("sb_tie_next_n", uint32'(rd_busy_n[1]), 1);
    check("sb_tie_data", rd_data_n[0], 32'h9A);

    // Reset discards a concurrent write and busy set.
    apply(0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 3, 0);
    idle(3, 0);
    check("pre_rst_x3", rd_data_n[0], 32'h33);
    apply(1, 1, 3, 32'h77, 0, 0, 0, 1, 3, 3, 9);
    idle(3, 9);
    check("rst_x3_data_n", rd_data_n[0], 0);
    check("rst_x3_data_b", rd_data_b[0], 0);
    check("rst_x3_busy", uint32'(rd_busy_b[0]), 0);
    check("rst_x9_busy", uint32'(rd_busy_n[1]), 0);
    idle(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
